// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALU
// operation encoding, FSM states and datapath mux-select codes.
package mips_ctrl_pkg;

   localparam int unsigned OP_W     = 6;
   localparam int unsigned ALU_OP_W = 3;

   // Opcodes (IR[31:26])
   localparam logic [OP_W-1:0] OP_ALU  = 6'b000000;
   localparam logic [OP_W-1:0] OP_JUMP = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

   // ALU operation encoding
   localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND   = 3'd2;
   localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 3'd3;

   // Writeback source
   localparam logic [1:0] MTR_ALUOUT = 2'b00;
   localparam logic [1:0] MTR_MDR    = 2'b01;
   localparam logic [1:0] MTR_PC     = 2'b10;

   // Destination register
   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   // ALU B input
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // Next-PC source
   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_R_WB     = 4'd3,
      S_EXEC_I   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

endpackage

// File: rtl/multicycle_cu_if.sv
// Control-unit <-> datapath/memory bundle.
//   master : control unit (takes opcode/mem_ready, drives control lines)
//   slave  : datapath side
// Optional trap line present when MULTICYCLE_CU_ILLEGAL_TRAP_EN is defined.
interface multicycle_cu_if #(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned ALUOP_W  = 3
);
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                pc_write_cond_ne;
   logic                ir_write;
   logic                i_or_d;
   logic                mem_read;
   logic                mem_write;
   logic [1:0]          mem_to_reg;
   logic                reg_write;
   logic [1:0]          reg_dst;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [ALUOP_W-1:0]  alu_op;
   logic [1:0]          pc_source;
   logic                instr_done;
   logic                mem_err;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
   logic                trap;
`endif

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_write_cond_ne, ir_write, i_or_d,
             mem_read, mem_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
             alu_src_b, alu_op, pc_source, instr_done, mem_err
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      , output trap
`endif
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_write_cond_ne, ir_write, i_or_d,
             mem_read, mem_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
             alu_src_b, alu_op, pc_source, instr_done, mem_err
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      , input trap
`endif
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout compare.
//   clk, rst    : clock, async active-low reset
//   busy        : FSM is in a state waiting on memory
//   ready       : memory completes this cycle
//   timeout_c   : combinational; wait budget exhausted with ready low
// TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   input  logic ready,
   output logic timeout_c
);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt;

   if (TIMEOUT > 0) begin : g_timeout
      assign timeout_c = busy && !ready && (cnt == CNT_W'(TIMEOUT - 1));
   end else begin : g_no_timeout
      assign timeout_c = 1'b0;
   end

   // Counts stalled cycles; any other cycle (completion, timeout, non-memory
   // state) clears it, so every entry into a wait state starts from zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                            cnt <= '0;
      else if (busy && !ready && !timeout_c) cnt <= cnt + CNT_W'(1);
      else                                 cnt <= '0;
   end
endmodule

// File: rtl/multicycle_cu.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared-ALU, single-memory datapath.
//   clk, rst : clock, async active-low reset (all outputs 0 while low)
//   bus      : multicycle_cu_if.master (opcode, mem_ready in; control out)
// MEM_TIMEOUT bounds each memory wait (0 disables).
// Macro MULTICYCLE_CU_ILLEGAL_TRAP_EN: undefined opcodes lock into TRAP with
// bus.trap=1 instead of executing as a NOP.
module multicycle_cu
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned ALUOP_W     = 3,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input logic             clk,
   input logic             rst,
   multicycle_cu_if.master bus
);
   state_t              state, state_nxt;
   logic [OPCODE_W-1:0] op_q;
   logic [OP_W-1:0]     op_dec;
   logic [OP_W-1:0]     op_lat;
   logic                mem_busy;
   logic                timeout_c;

   assign op_dec   = OP_W'(bus.opcode);
   assign op_lat   = OP_W'(op_q);
   assign mem_busy = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

   mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .busy      (mem_busy),
      .ready     (bus.mem_ready),
      .timeout_c (timeout_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_nxt;
   end

   // Opcode latch; IR may change after DECODE, later states use this copy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   op_q <= '0;
      else if (state == S_DECODE) op_q <= bus.opcode;
   end

   // Next state and Moore output decode
   always_comb begin
      state_nxt            = state;
      bus.pc_write         = 1'b0;
      bus.pc_write_cond    = 1'b0;
      bus.pc_write_cond_ne = 1'b0;
      bus.ir_write         = 1'b0;
      bus.i_or_d           = 1'b0;
      bus.mem_read         = 1'b0;
      bus.mem_write        = 1'b0;
      bus.mem_to_reg       = MTR_ALUOUT;
      bus.reg_write        = 1'b0;
      bus.reg_dst          = RD_RT;
      bus.alu_src_a        = 1'b0;
      bus.alu_src_b        = SRCB_B;
      bus.alu_op           = ALUOP_W'(ALU_ADD);
      bus.pc_source        = PCS_ALU;
      bus.instr_done       = 1'b0;
      bus.mem_err          = 1'b0;
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      bus.trap             = 1'b0;
`endif
      // Outputs gated by reset so an in-flight access drops immediately
      if (rst) begin
         unique case (state)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = SRCB_4;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
               if (bus.mem_ready)  state_nxt = S_DECODE;
               else if (timeout_c) bus.mem_err = 1'b1;  // retry same PC
            end
            S_DECODE: begin
               bus.alu_src_b = SRCB_IMM_SH;
               unique case (op_dec)
                  OP_ALU:          state_nxt = S_EXEC_R;
                  OP_ADDI, OP_ANDI: state_nxt = S_EXEC_I;
                  OP_LW, OP_SW:    state_nxt = S_MEM_ADDR;
                  OP_BEQ, OP_BNE:  state_nxt = S_BRANCH;
                  OP_JUMP:         state_nxt = S_JUMP;
                  OP_JAL:          state_nxt = S_JAL;
                  default: begin
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
                     state_nxt = S_TRAP;
`else
                     state_nxt      = S_FETCH;
                     bus.instr_done = 1'b1;
`endif
                  end
               endcase
            end
            S_EXEC_R: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = ALUOP_W'(ALU_FUNCT);
               state_nxt     = S_R_WB;
            end
            S_R_WB: begin
               bus.reg_write  = 1'b1;
               bus.reg_dst    = RD_RD;
               bus.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end
            S_EXEC_I: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = SRCB_IMM;
               bus.alu_op    = (op_lat == OP_ANDI) ? ALUOP_W'(ALU_AND) : ALUOP_W'(ALU_ADD);
               state_nxt     = S_I_WB;
            end
            S_I_WB: begin
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end
            S_MEM_ADDR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = SRCB_IMM;
               state_nxt     = (op_lat == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               bus.mem_read = 1'b1;
               bus.i_or_d   = 1'b1;
               if (bus.mem_ready) state_nxt = S_MEM_WB;
               else if (timeout_c) begin
                  bus.mem_err = 1'b1;
                  state_nxt   = S_FETCH;
               end
            end
            S_MEM_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = MTR_MDR;
               bus.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end
            S_MEM_WR: begin
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
               if (bus.mem_ready) begin
                  bus.instr_done = 1'b1;
                  state_nxt      = S_FETCH;
               end else if (timeout_c) begin
                  bus.mem_err = 1'b1;
                  state_nxt   = S_FETCH;
               end
            end
            S_BRANCH: begin
               bus.alu_src_a        = 1'b1;
               bus.alu_op           = ALUOP_W'(ALU_SUB);
               bus.pc_source        = PCS_ALUOUT;
               bus.pc_write_cond    = (op_lat == OP_BEQ);
               bus.pc_write_cond_ne = (op_lat == OP_BNE);
               bus.instr_done       = 1'b1;
               state_nxt            = S_FETCH;
            end
            S_JUMP: begin
               bus.pc_write   = 1'b1;
               bus.pc_source  = PCS_JUMP;
               bus.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end
            S_JAL: begin
               // PC still holds PC+4 here, so it is the link value
               bus.pc_write   = 1'b1;
               bus.pc_source  = PCS_JUMP;
               bus.reg_write  = 1'b1;
               bus.reg_dst    = RD_RA;
               bus.mem_to_reg = MTR_PC;
               bus.instr_done = 1'b1;
               state_nxt      = S_FETCH;
            end
            S_TRAP: begin
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
               bus.trap = 1'b1;
`else
               state_nxt = S_FETCH;
`endif
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu (MEM_TIMEOUT=4). Inputs change and outputs
// are sampled just after the falling edge; each step covers one FSM cycle.
module tb_multicycle_cu;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   multicycle_cu_if #(.OPCODE_W(6), .ALUOP_W(3)) bus ();

   multicycle_cu #(.OPCODE_W(6), .ALUOP_W(3), .MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_write_cond_ne;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       mem_err;
   } exp_t;

   function automatic exp_t obs();
      exp_t c;
      c.pc_write = bus.pc_write;           c.pc_write_cond = bus.pc_write_cond;
      c.pc_write_cond_ne = bus.pc_write_cond_ne;
      c.ir_write = bus.ir_write;           c.i_or_d = bus.i_or_d;
      c.mem_read = bus.mem_read;           c.mem_write = bus.mem_write;
      c.mem_to_reg = bus.mem_to_reg;       c.reg_write = bus.reg_write;
      c.reg_dst = bus.reg_dst;             c.alu_src_a = bus.alu_src_a;
      c.alu_src_b = bus.alu_src_b;         c.alu_op = bus.alu_op;
      c.pc_source = bus.pc_source;         c.instr_done = bus.instr_done;
      c.mem_err = bus.mem_err;
      return c;
   endfunction

   // Expected control words, written from the state table
   function automatic exp_t e_fetch(input logic rdy, input logic err);
      exp_t c = '0;
      c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
      c.mem_err = err;
      return c;
   endfunction
   function automatic exp_t e_decode(input logic nop);
      exp_t c = '0;
      c.alu_src_b = 2'b11; c.instr_done = nop;
      return c;
   endfunction
   function automatic exp_t e_exec(input logic [1:0] srcb, input logic [2:0] op);
      exp_t c = '0;
      c.alu_src_a = 1'b1; c.alu_src_b = srcb; c.alu_op = op;
      return c;
   endfunction
   function automatic exp_t e_wb(input logic [1:0] dst, input logic [1:0] mtr);
      exp_t c = '0;
      c.reg_write = 1'b1; c.reg_dst = dst; c.mem_to_reg = mtr; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic exp_t e_mem(input logic wr, input logic done, input logic err);
      exp_t c = '0;
      c.i_or_d = 1'b1; c.mem_read = !wr; c.mem_write = wr; c.instr_done = done;
      c.mem_err = err;
      return c;
   endfunction
   function automatic exp_t e_branch(input logic ne);
      exp_t c = '0;
      c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_source = 2'b01;
      c.pc_write_cond = !ne; c.pc_write_cond_ne = ne; c.instr_done = 1'b1;
      return c;
   endfunction
   function automatic exp_t e_jump(input logic link);
      exp_t c = '0;
      c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
      if (link) begin
         c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      end
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply inputs, check outputs, advance to the next falling edge
   task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input exp_t e);
      bus.opcode    = op;
      bus.mem_ready = rdy;
      #1;
      check(tag, 32'(obs()), 32'(e));
      @(negedge clk);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b0;
      bus.opcode    = 6'h00;
      bus.mem_ready = 1'b0;
      #1;
      check("rst_idle", 32'(obs()), 32'(exp_t'('0)));
      bus.mem_ready = 1'b1;
      #1;
      check("rst_ready", 32'(obs()), 32'(exp_t'('0)));
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      check("rst_trap", 32'(bus.trap), 32'(0));
`endif
      @(negedge clk);
      rst = 1'b1;

      // ADD (R-type)
      cyc("add_fetch", 6'h00, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("add_dec",   6'h00, 1'b1, e_decode(1'b0));
      cyc("add_exec",  6'h3f, 1'b1, e_exec(2'b00, 3'd3));
      cyc("add_wb",    6'h3f, 1'b1, e_wb(2'b01, 2'b00));
      // ADDI / ANDI; opcode scrambled after DECODE to exercise the latch
      cyc("addi_fetch", 6'h08, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("addi_dec",   6'h08, 1'b1, e_decode(1'b0));
      cyc("addi_exec",  6'h0c, 1'b1, e_exec(2'b10, 3'd0));
      cyc("addi_wb",    6'h0c, 1'b1, e_wb(2'b00, 2'b00));
      cyc("andi_fetch", 6'h0c, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("andi_dec",   6'h0c, 1'b1, e_decode(1'b0));
      cyc("andi_exec",  6'h08, 1'b1, e_exec(2'b10, 3'd2));
      cyc("andi_wb",    6'h08, 1'b1, e_wb(2'b00, 2'b00));
      // LW: ready arrives on the 4th MEM_RD cycle, same cycle as the timeout
      cyc("lw_fetch", 6'h23, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("lw_dec",   6'h23, 1'b1, e_decode(1'b0));
      cyc("lw_addr",  6'h23, 1'b1, e_exec(2'b10, 3'd0));
      for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 6'h23, 1'b0, e_mem(1'b0, 1'b0, 1'b0));
      cyc("lw_rd_done", 6'h23, 1'b1, e_mem(1'b0, 1'b0, 1'b0));
      cyc("lw_wb",      6'h23, 1'b1, e_wb(2'b00, 2'b01));
      // SW that times out: mem_err on the 4th cycle, no instr_done
      cyc("sw_fetch", 6'h2b, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("sw_dec",   6'h2b, 1'b1, e_decode(1'b0));
      cyc("sw_addr",  6'h2b, 1'b1, e_exec(2'b10, 3'd0));
      for (int i = 0; i < 3; i++) cyc("sw_wait", 6'h2b, 1'b0, e_mem(1'b1, 1'b0, 1'b0));
      cyc("sw_timeout", 6'h2b, 1'b0, e_mem(1'b1, 1'b0, 1'b1));
      // BEQ then BNE
      cyc("beq_fetch",  6'h04, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("beq_dec",    6'h04, 1'b1, e_decode(1'b0));
      cyc("beq_branch", 6'h04, 1'b1, e_branch(1'b0));
      cyc("bne_fetch",  6'h05, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("bne_dec",    6'h05, 1'b1, e_decode(1'b0));
      cyc("bne_branch", 6'h05, 1'b1, e_branch(1'b1));
      // J and JAL
      cyc("j_fetch",   6'h02, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("j_dec",     6'h02, 1'b1, e_decode(1'b0));
      cyc("j_jump",    6'h02, 1'b1, e_jump(1'b0));
      cyc("jal_fetch", 6'h03, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("jal_dec",   6'h03, 1'b1, e_decode(1'b0));
      cyc("jal_jump",  6'h03, 1'b1, e_jump(1'b1));
      // FETCH timeout retries in FETCH with a fresh budget
      for (int i = 0; i < 3; i++) cyc("fetch_wait", 6'h00, 1'b0, e_fetch(1'b0, 1'b0));
      cyc("fetch_timeout", 6'h00, 1'b0, e_fetch(1'b0, 1'b1));
      for (int i = 0; i < 3; i++) cyc("fetch_retry", 6'h00, 1'b0, e_fetch(1'b0, 1'b0));
      cyc("fetch_retry_ok", 6'h00, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("retry_dec",      6'h00, 1'b1, e_decode(1'b0));
      cyc("retry_exec",     6'h00, 1'b1, e_exec(2'b00, 3'd3));
      cyc("retry_wb",       6'h00, 1'b1, e_wb(2'b01, 2'b00));
      // Reset asserted mid MEM_RD drops everything immediately
      cyc("lw2_fetch", 6'h23, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("lw2_dec",   6'h23, 1'b1, e_decode(1'b0));
      cyc("lw2_addr",  6'h23, 1'b1, e_exec(2'b10, 3'd0));
      cyc("lw2_rd",    6'h23, 1'b0, e_mem(1'b0, 1'b0, 1'b0));
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_rd", 32'(obs()), 32'(exp_t'('0)));
      @(negedge clk);
      rst = 1'b1;
      cyc("post_rst_fetch", 6'h00, 1'b0, e_fetch(1'b0, 1'b0));
      cyc("post_rst_ok",    6'h00, 1'b1, e_fetch(1'b1, 1'b0));
      // Undefined opcode 111111
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      cyc("ill_dec", 6'h3f, 1'b1, e_decode(1'b0));
      for (int i = 0; i < 4; i++) begin
         bus.mem_ready = 1'b1;
         #1;
         check("trap_ctrl", 32'(obs()), 32'(exp_t'('0)));
         check("trap_flag", 32'(bus.trap), 32'(1));
         @(negedge clk);
      end
`else
      cyc("ill_nop",   6'h3f, 1'b1, e_decode(1'b1));
      cyc("ill_fetch", 6'h00, 1'b1, e_fetch(1'b1, 1'b0));
      cyc("ill_next",  6'h00, 1'b1, e_decode(1'b0));
`endif
      // Reset always returns to FETCH
      rst = 1'b0;
      #1;
      check("rst_final", 32'(obs()), 32'(exp_t'('0)));
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
      check("rst_trap_clr", 32'(bus.trap), 32'(0));
`endif
      @(negedge clk);
      rst = 1'b1;
      cyc("final_fetch", 6'h00, 1'b1, e_fetch(1'b1, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multicycle MIPS control unit; replaces the single-cycle decoder with a Moore FSM that sequences fetch/decode/execute/memory/writeback over several cycles.
- Drives the shared-ALU, single-memory datapath and waits on a memory ready handshake.
- Supports R-type, ADDI, ANDI, LW, SW, BEQ, BNE, J and JAL.
- Bounds every memory wait with a timeout counter.

Parameters:
- OPCODE_W, 6, opcode width
- ALUOP_W, 3, alu_op width
- MEM_TIMEOUT, 16, max wait cycles for mem_ready; 0 disables the timeout

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- opcode  input  OPCODE_W  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (BEQ)
- pc_write_cond_ne  output  1  PC load if ALU not zero (BNE)
- ir_write  output  1  IR load
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  read request
- mem_write  output  1  write request
- mem_to_reg  output  2  writeback source: 00=ALUOut, 01=MDR, 10=PC
- reg_write  output  1  register file write
- reg_dst  output  2  destination: 00=rt, 01=rd, 10=r31
- alu_src_a  output  1  ALU A input: 0=PC, 1=A register
- alu_src_b  output  2  ALU B input: 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  output  ALUOP_W  ALU operation (package encoding)
- pc_source  output  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse in the last state of each instruction
- mem_err  output  1  one-cycle pulse when a memory access times out

Behaviour:
- Reset (rst=0, async): state=FETCH, latched opcode=0, wait counter=0; all outputs forced 0 while rst=0.
- Outputs are a Moore decode of the current state, plus the latched opcode where noted. Unlisted outputs are 0 in each state.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - ir_write=pc_write=mem_ready, pc_source=00.
  - Next: stay while !mem_ready; on mem_ready go to DECODE.
- DECODE:
  - Latches opcode. Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target).
  - Next: ALU(000000)->EXEC_R; ADDI/ANDI->EXEC_I; LW/SW->MEM_ADDR; BEQ/BNE->BRANCH; J->JUMP; JAL->JAL_S; any other opcode->FETCH with instr_done=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD (ADDI) or AND (ANDI) -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, i_or_d=1; wait for mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01, reg_dst=00, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; wait for mem_ready -> FETCH, instr_done=1 on the ready cycle.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01; pc_write_cond=1 (BEQ) or pc_write_cond_ne=1 (BNE); instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
- JAL_S: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1 -> FETCH. PC register still holds PC+4 for the link value.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle mem_ready=0 in those states.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 with mem_ready=0: mem_err pulses, access is abandoned, next state FETCH.
  - FETCH timeout re-enters FETCH and retries at the same PC (PC not written). No register or memory write occurs for an abandoned access.
  - mem_ready on the timeout cycle wins: normal completion, no mem_err.
- Reset mid-access drops mem_read/mem_write in the same cycle (async).

Optional Feature:
- Macro MULTICYCLE_CU_ILLEGAL_TRAP_EN.
- Defined: adds output trap (1 bit, reset 0). Undefined opcode in DECODE -> TRAP state; trap=1 and all other outputs 0. TRAP is left only by reset.
- Undefined: undefined opcode executes as NOP (DECODE->FETCH, instr_done=1); no trap port.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (ALU, ADDI, ANDI, LW, SW, BEQ, BNE, JUMP, JAL)
  - alu_op encoding: ADD=0, SUB=1, AND=2, FUNCT=3
  - state enumeration
  - mux-select constants for mem_to_reg, reg_dst, alu_src_b, pc_source
- One natural sub-module: mem_wait_timer (wait counter plus timeout compare). The FSM and output decode stay in multicycle_cu.

Test Plan:
- ADD R-type, mem_ready=1 always -> FETCH,DECODE,EXEC_R,R_WB (4 cycles); reg_write=1, reg_dst=01 in cycle 4; instr_done pulses once.
- LW with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles at i_or_d=1; MEM_WB has mem_to_reg=01; total 8 cycles.
- BEQ then BNE -> BRANCH asserts alu_op=SUB, pc_source=01, with pc_write_cond=1 for BEQ only and pc_write_cond_ne=1 for BNE only.
- JAL -> JAL_S has pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
- MEM_TIMEOUT=4, SW with mem_ready=0 -> mem_write high 4 cycles; mem_err pulses once in the 4th cycle; next state FETCH; instr_done never pulses.
- rst driven low mid-MEM_RD -> all outputs 0 immediately; after release, first cycle is FETCH with mem_read=1.
- Opcode 111111 -> NOP (2 cycles, instr_done=1); with MULTICYCLE_CU_ILLEGAL_TRAP_EN, trap=1 and the FSM stays in TRAP until reset.
